// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter with long-latency result FIFO and scoreboard
//
// Purpose: merges main-pipeline writebacks with buffered long-latency results
// onto the single register-file write port, and tracks registers whose value
// is still owed by a long-latency op so decode can stall on them.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   p_we, p_wa, p_wd      main-pipeline writeback request (highest priority)
//   issue_valid, issue_rd long-latency op issued; marks issue_rd pending
//   ll_valid, ll_rd,      long-latency result offered; accepted when
//   ll_data, ll_ready     ll_valid && ll_ready at posedge
//   ra1, ra2, hazard      decode sources; hazard when either is pending
//   we, wa, wd            register-file write port
//   fifo_count            buffered result count
//   err                   sticky protocol-violation flag
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_we,
  input  logic [4:0]  p_wa,
  input  logic [31:0] p_wd,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        hazard,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic [3:0]  fifo_count,
  output logic        err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]    count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic          err_q, err_d;

  logic        pclaim;
  logic        pop;
  logic        accept;
  logic        push;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        viol;

  // A write to r0 is meaningless, so it never claims the port.
  assign pclaim   = p_we && (p_wa != 5'd0);
  assign pop      = !pclaim && (count_q != 4'd0);
  // A slot freed by this cycle's pop can be refilled at the same edge.
  assign ll_ready = (count_q < DEPTH_C) || pop;
  assign accept   = ll_valid && ll_ready;
  assign push     = accept && (ll_rd != 5'd0);

  always_comb begin
    we = 1'b0;
    wa = 5'd0;
    wd = 32'd0;
    if (pclaim) begin
      we = 1'b1;
      wa = p_wa;
      wd = p_wd;
    end else if (pop) begin
      we = 1'b1;
      wa = fifo_rd_q[rd_ptr_q];
      wd = fifo_data_q[rd_ptr_q];
    end
  end

  // Pending state is sampled registered only: an issue this cycle cannot
  // stall the instruction already in decode.
  assign hazard     = pending_q[ra1] || pending_q[ra2];
  assign fifo_count = count_q;
  assign err        = err_q;

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (issue_valid && (issue_rd != 5'd0)) set_vec = 32'd1 << issue_rd;
    if (pop) clr_vec = 32'd1 << fifo_rd_q[rd_ptr_q];
    // Set is applied after clear so a re-issue of the retiring register wins.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    viol = 1'b0;
    if (issue_valid && (issue_rd != 5'd0) && pending_q[issue_rd]) viol = 1'b1;
    if (pclaim && pending_q[p_wa]) viol = 1'b1;
    if (accept && (ll_rd != 5'd0) && !pending_q[ll_rd]) viol = 1'b1;
    err_d = err_q || viol;
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 4'd1;
    else if (pop && !push) count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= 4'd0;
      pending_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ll_rd;
      fifo_data_q[wr_ptr_q] <= ll_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_we;
  logic [4:0]  p_wa;
  logic [31:0] p_wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic [4:0]  ra1, ra2;
  logic        hazard;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [3:0]  fifo_count;
  logic        err;

  int vecs = 0;
  int errs = 0;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .ra1(ra1), .ra2(ra2), .hazard(hazard),
    .we(we), .wa(wa), .wd(wd),
    .fifo_count(fifo_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_we = 1'b0; p_wa = 5'd0; p_wd = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
    ra1 = 5'd0; ra2 = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    vecs++; if (fifo_count !== 4'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    vecs++; if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0) begin errs++; $display("FAIL reset_wport got we=%b wa=%0d wd=%h exp 0/0/0", we, wa, wd); end
    vecs++; if (ll_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", ll_ready); end
    vecs++; if (hazard !== 1'b0 || err !== 1'b0) begin errs++; $display("FAIL reset_flags got hazard=%b err=%b exp 0/0", hazard, err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd5; ra1 = 5'd5;
    #1;
    vecs++; if (hazard !== 1'b0) begin errs++; $display("FAIL basic_nobypass got %b exp 0", hazard); end
    tick();
    issue_valid = 1'b0;
    #1;
    vecs++; if (hazard !== 1'b1) begin errs++; $display("FAIL basic_haz_issue1 got %b exp 1", hazard); end
    tick(); tick();
    ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 32'hDEADBEEF;
    #1;
    vecs++; if (ll_ready !== 1'b1 || we !== 1'b0) begin errs++; $display("FAIL basic_offer got ready=%b we=%b exp 1/0", ll_ready, we); end
    tick();
    ll_valid = 1'b0;
    #1;
    vecs++; if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin errs++; $display("FAIL basic_write got we=%b wa=%0d wd=%h exp 1/5/deadbeef", we, wa, wd); end
    vecs++; if (hazard !== 1'b1) begin errs++; $display("FAIL basic_haz_pop got %b exp 1", hazard); end
    tick();
    vecs++; if (hazard !== 1'b0 || we !== 1'b0 || fifo_count !== 4'd0) begin errs++; $display("FAIL basic_after got hazard=%b we=%b count=%0d exp 0/0/0", hazard, we, fifo_count); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL basic_err got %b exp 0", err); end
    idle();
  endtask

  task automatic test_priority();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h0000_0077;
    p_we = 1'b1; p_wa = 5'd3; p_wd = 32'h0000_0033;
    #1;
    vecs++; if (we !== 1'b1 || wa !== 5'd3) begin errs++; $display("FAIL prio_c0 got we=%b wa=%0d exp 1/3", we, wa); end
    for (int i = 1; i < 4; i++) begin
      tick();
      ll_valid = 1'b0;
      #1;
      vecs++; if (wa !== 5'd3 || wd !== 32'h33 || fifo_count !== 4'd1) begin errs++; $display("FAIL prio_c%0d got wa=%0d wd=%h count=%0d exp 3/33/1", i, wa, wd, fifo_count); end
    end
    tick();
    p_we = 1'b0;
    #1;
    vecs++; if (we !== 1'b1 || wa !== 5'd7 || wd !== 32'h77) begin errs++; $display("FAIL prio_drain got we=%b wa=%0d wd=%h exp 1/7/77", we, wa, wd); end
    tick();
    vecs++; if (we !== 1'b0 || fifo_count !== 4'd0) begin errs++; $display("FAIL prio_empty got we=%b count=%0d exp 0/0", we, fifo_count); end
    idle();
  endtask

  task automatic test_full();
    tick(); issue_valid = 1'b1; issue_rd = 5'd10;
    tick(); issue_rd = 5'd11;
    tick(); issue_rd = 5'd12;
    tick(); issue_valid = 1'b0;
    p_we = 1'b1; p_wa = 5'd3; p_wd = 32'h3;
    ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hA;
    #1;
    vecs++; if (ll_ready !== 1'b1) begin errs++; $display("FAIL full_rdy0 got %b exp 1", ll_ready); end
    tick(); ll_rd = 5'd11; ll_data = 32'hB;
    tick(); ll_rd = 5'd12; ll_data = 32'hC;
    #1;
    vecs++; if (fifo_count !== 4'd2 || ll_ready !== 1'b0) begin errs++; $display("FAIL full_full got count=%0d ready=%b exp 2/0", fifo_count, ll_ready); end
    tick();
    vecs++; if (fifo_count !== 4'd2 || ll_ready !== 1'b0 || wa !== 5'd3) begin errs++; $display("FAIL full_held got count=%0d ready=%b wa=%0d exp 2/0/3", fifo_count, ll_ready, wa); end
    tick(); p_we = 1'b0;
    #1;
    vecs++; if (ll_ready !== 1'b1 || we !== 1'b1 || wa !== 5'd10 || wd !== 32'hA) begin errs++; $display("FAIL full_pop1 got ready=%b we=%b wa=%0d wd=%h exp 1/1/10/a", ll_ready, we, wa, wd); end
    tick(); ll_valid = 1'b0;
    #1;
    vecs++; if (fifo_count !== 4'd2 || wa !== 5'd11 || wd !== 32'hB) begin errs++; $display("FAIL full_pop2 got count=%0d wa=%0d wd=%h exp 2/11/b", fifo_count, wa, wd); end
    tick();
    vecs++; if (fifo_count !== 4'd1 || wa !== 5'd12 || wd !== 32'hC) begin errs++; $display("FAIL full_pop3 got count=%0d wa=%0d wd=%h exp 1/12/c", fifo_count, wa, wd); end
    tick();
    vecs++; if (fifo_count !== 4'd0 || we !== 1'b0 || err !== 1'b0) begin errs++; $display("FAIL full_done got count=%0d we=%b err=%b exp 0/0/0", fifo_count, we, err); end
    idle();
  endtask

  task automatic test_zero();
    tick(); issue_valid = 1'b1; issue_rd = 5'd9;
    tick(); issue_valid = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    p_we = 1'b1; p_wa = 5'd0; p_wd = 32'h1234;
    #1;
    vecs++; if (we !== 1'b0) begin errs++; $display("FAIL zero_ignored got we=%b exp 0", we); end
    tick(); ll_valid = 1'b0;
    #1;
    vecs++; if (we !== 1'b1 || wa !== 5'd9 || wd !== 32'h99) begin errs++; $display("FAIL zero_drain got we=%b wa=%0d wd=%h exp 1/9/99", we, wa, wd); end
    tick(); p_we = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h55;
    #1;
    vecs++; if (ll_ready !== 1'b1 || fifo_count !== 4'd0) begin errs++; $display("FAIL zero_offer got ready=%b count=%0d exp 1/0", ll_ready, fifo_count); end
    tick(); ll_valid = 1'b0;
    #1;
    vecs++; if (we !== 1'b0 || fifo_count !== 4'd0 || err !== 1'b0) begin errs++; $display("FAIL zero_discard got we=%b count=%0d err=%b exp 0/0/0", we, fifo_count, err); end
    idle();
  endtask

  task automatic test_err();
    tick(); issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_first got %b exp 0", err); end
    tick(); issue_valid = 1'b0;
    #1;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_dup got %b exp 1", err); end
    tick(); tick(); tick();
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b exp 1", err); end
    do_reset();
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_cleared got %b exp 0", err); end
    ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'hC0;
    tick(); ll_valid = 1'b0;
    #1;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_unissued got %b exp 1", err); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    tick(); issue_valid = 1'b1; issue_rd = 5'd20;
    tick(); issue_rd = 5'd21;
    tick(); issue_rd = 5'd22;
    tick(); issue_valid = 1'b0;
    p_we = 1'b1; p_wa = 5'd3; p_wd = 32'h3;
    ll_valid = 1'b1; ll_rd = 5'd20; ll_data = 32'h20;
    tick(); ll_rd = 5'd21; ll_data = 32'h21;
    tick(); ll_valid = 1'b0;
    ra1 = 5'd20; ra2 = 5'd22;
    #1;
    vecs++; if (fifo_count !== 4'd2 || hazard !== 1'b1) begin errs++; $display("FAIL rmid_pre got count=%0d hazard=%b exp 2/1", fifo_count, hazard); end
    p_we = 1'b0;
    rst_n = 1'b0;
    #1;
    vecs++; if (fifo_count !== 4'd0 || we !== 1'b0 || hazard !== 1'b0 || ll_ready !== 1'b1) begin errs++; $display("FAIL rmid_now got count=%0d we=%b hazard=%b ready=%b exp 0/0/0/1", fifo_count, we, hazard, ll_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++; if (we !== 1'b0 || fifo_count !== 4'd0) begin errs++; $display("FAIL rmid_post%0d got we=%b count=%0d exp 0/0", i, we, fifo_count); end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_priority();
    test_full();
    test_zero();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
